// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB transmit-side blocks.
package usb_pkg;

    // Native byte width of the USB core's data path.
    localparam int USB_BYTE_W = 8;

    // Output-stage state: EMPTY means nothing is offered to the core,
    // LOADED means data_in holds a byte waiting for its strobe.
    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } out_state_e;

endpackage

// File: rtl/usb_tx_feeder_if.sv
// usb_tx_feeder_if: byte handshake between the feeder and the USB core.
// The feeder (master) offers data_in/data_in_valid; the core (slave)
// answers with a one-cycle data_strobe when it takes the byte.
interface usb_tx_feeder_if
    import usb_pkg::*;
#(
    parameter int DATA_W = USB_BYTE_W
);
    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic              data_strobe;

    modport master (output data_in, output data_in_valid, input  data_strobe);
    modport slave  (input  data_in, input  data_in_valid, output data_strobe);
endinterface

// File: rtl/usb_sync_fifo.sv
// usb_sync_fifo: single-clock FIFO with wrap-bit pointers (modulo 2*DEPTH).
// Read data is presented combinationally from the head entry; the
// consumer registers it. Writes while full and reads while empty are ignored.
module usb_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_wr, do_rd;

    assign do_wr = wr_en && !full  && !flush;
    assign do_rd = rd_en && !empty && !flush;

    // Pointer advance; flush returns both pointers to zero.
    always_comb begin
        // NOTE: every always_comb output is assigned a default first, so no path can leave it holding a value (that would infer a latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of process order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are meaningful, and that keeps it mappable to RAM.
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/usb_tx_feeder.sv
// usb_tx_feeder: buffers user bytes in a FIFO behind a registered output
// stage feeding the USB core's data_in / data_in_valid / data_strobe handshake.
// Define USB_TX_FEEDER_PATTERN_EN to build the incrementing test-pattern source;
// without it the pattern inputs are ignored and pattern_busy is tied low.
module usb_tx_feeder
    import usb_pkg::*;
#(
    parameter int DATA_W      = USB_BYTE_W,
    parameter int DEPTH       = 16,
    parameter int PATTERN_LEN = 3
) (
    input  logic                     clk_48,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_en,
    output logic                     full,
    input  logic                     flush,
    output logic [$clog2(DEPTH)+1:0] count,
    output logic                     overflow,
    usb_tx_feeder_if.master          usb,
    input  logic                     pattern_en,
    input  logic [DATA_W-1:0]        pattern_start,
    output logic                     pattern_busy
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(DEPTH) + 2;

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overflow_q, overflow_d;

    logic              fifo_wr, fifo_rd, fifo_empty, bypass;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [PTR_W-1:0]  fifo_level;

    logic              pat_avail, pat_take;
    logic [DATA_W-1:0] pat_byte;

    // A byte that goes straight into an idle output stage bypasses storage;
    // the FIFO itself rejects writes while full, so a same-cycle strobe never rescues one.
    assign fifo_wr = wr_en && !flush && !bypass;

    usb_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk_48),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (fifo_wr),
        .wr_data (wr_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Output-stage state register.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Next state: refill whenever the stage is empty or its byte is strobed.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        fifo_rd  = 1'b0;
        bypass   = 1'b0;
        pat_take = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else if (state_q == EMPTY || usb.data_strobe) begin
            if (pat_avail) begin
                state_d  = LOADED;
                data_d   = pat_byte;
                pat_take = 1'b1;
            end else if (!fifo_empty) begin
                state_d = LOADED;
                data_d  = fifo_rd_data;
                fifo_rd = 1'b1;
            end else if (wr_en) begin
                state_d = LOADED;
                data_d  = wr_data;
                bypass  = 1'b1;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    // FSM outputs towards the USB core.
    always_comb begin
        usb.data_in_valid = (state_q == LOADED);
        usb.data_in       = data_q;
    end

    // Overflow is sticky until flush; a write is dropped whenever storage was full.
    always_comb begin
        overflow_d = flush ? 1'b0 : (overflow_q || (wr_en && full));
    end

    // Output data register and overflow flag.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
    assign count    = CNT_W'(fifo_level) + CNT_W'(state_q == LOADED);

`ifdef USB_TX_FEEDER_PATTERN_EN
    logic              pat_en_q, pat_en_d;
    logic              pat_busy_q, pat_busy_d;
    logic [DATA_W-1:0] pat_byte_q, pat_byte_d;
    logic [7:0]        pat_left_q, pat_left_d;

    // Pattern run control: start on a rising edge when idle, step on each take,
    // and stay busy until the last pattern byte has been strobed.
    always_comb begin
        pat_en_d   = pattern_en;
        pat_busy_d = pat_busy_q;
        pat_byte_d = pat_byte_q;
        pat_left_d = pat_left_q;
        if (flush) begin
            pat_busy_d = 1'b0;
            pat_left_d = '0;
        end else if (!pat_busy_q) begin
            if (pattern_en && !pat_en_q) begin
                pat_busy_d = 1'b1;
                pat_byte_d = pattern_start;
                pat_left_d = 8'(PATTERN_LEN);
            end
        end else begin
            if (pat_take) begin
                pat_byte_d = pat_byte_q + 1'b1;
                pat_left_d = pat_left_q - 1'b1;
            end
            // With nothing left to issue, the loaded byte is the final pattern byte.
            if (pat_left_q == '0 && state_q == LOADED && usb.data_strobe) pat_busy_d = 1'b0;
        end
    end

    // Pattern generator registers.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            pat_en_q   <= 1'b0;
            pat_busy_q <= 1'b0;
            pat_byte_q <= '0;
            pat_left_q <= '0;
        end else begin
            pat_en_q   <= pat_en_d;
            pat_busy_q <= pat_busy_d;
            pat_byte_q <= pat_byte_d;
            pat_left_q <= pat_left_d;
        end
    end

    assign pat_avail    = pat_busy_q && (pat_left_q != '0);
    assign pat_byte     = pat_byte_q;
    assign pattern_busy = pat_busy_q;
`else
    logic unused_pattern;

    assign pat_avail      = 1'b0;
    assign pat_byte       = '0;
    assign pattern_busy   = 1'b0;
    assign unused_pattern = ^{pattern_en, pattern_start, pat_take};
`endif

endmodule

// File: tb/tb_usb_tx_feeder.sv
// tb_usb_tx_feeder: scoreboard bench for usb_tx_feeder. The reference model
// is a byte queue: everything accepted and not yet strobed, head first.
module tb_usb_tx_feeder;
    import usb_pkg::*;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 16;
    localparam int PATTERN_LEN = 3;
    localparam int CNT_W       = $clog2(DEPTH) + 2;

    logic              clk_48 = 1'b0;
    logic              rst_n  = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_en = 1'b0;
    logic              full;
    logic              flush = 1'b0;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              pattern_en = 1'b0;
    logic [DATA_W-1:0] pattern_start = '0;
    logic              pattern_busy;

    usb_tx_feeder_if #(.DATA_W(DATA_W)) usb ();

    usb_tx_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PATTERN_LEN(PATTERN_LEN)) dut (
        .clk_48        (clk_48),
        .rst_n         (rst_n),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .full          (full),
        .flush         (flush),
        .count         (count),
        .overflow      (overflow),
        .usb           (usb.master),
        .pattern_en    (pattern_en),
        .pattern_start (pattern_start),
        .pattern_busy  (pattern_busy)
    );

    always #5 clk_48 = ~clk_48;

    int                n_tests = 0;
    int                n_fail  = 0;
    bit                model_on = 1'b1;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] seen_q[$];
    bit                exp_ovf = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, then wait for the next edge.
    task automatic cycle(bit w, logic [DATA_W-1:0] d, bit s, bit f);
        wr_en           = w;
        wr_data         = d;
        usb.data_strobe = s;
        flush           = f;
        @(posedge clk_48);
        #1;
    endtask

    // Scoreboard: compare DUT outputs with the queue model on every falling
    // edge, then advance the model with the inputs the next rising edge will see.
    always @(negedge clk_48) begin
        bit was_full;
        if (!rst_n) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            check("rst_valid", usb.data_in_valid, 0);
            check("rst_data_in", usb.data_in, 0);
            check("rst_count", count, 0);
            check("rst_full", full, 0);
            check("rst_overflow", overflow, 0);
            check("rst_busy", pattern_busy, 0);
        end else if (model_on) begin
            check("valid", usb.data_in_valid, exp_q.size() > 0);
            check("count", count, exp_q.size());
            check("full", full, exp_q.size() == DEPTH + 1);
            check("overflow", overflow, exp_ovf);
            check("pattern_busy", pattern_busy, 0);
            if (exp_q.size() > 0) check("data_in", usb.data_in, exp_q[0]);
            was_full = (exp_q.size() == DEPTH + 1);
            if (flush) begin
                exp_q.delete();
                exp_ovf = 1'b0;
            end else begin
                if (usb.data_strobe && exp_q.size() > 0) void'(exp_q.pop_front());
                if (wr_en) begin
                    if (was_full) exp_ovf = 1'b1;
                    else          exp_q.push_back(wr_data);
                end
            end
        end else begin
            if (usb.data_in_valid && usb.data_strobe) seen_q.push_back(usb.data_in);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        usb.data_strobe = 1'b0;
        repeat (3) @(posedge clk_48);
        #1 rst_n = 1'b1;
        cycle(0, 0, 0, 0);

        // Three writes, each byte strobed two cycles after it appears.
        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h02, 0, 0);
        cycle(1, 8'h03, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("t1_last_byte", usb.data_in, 8'h03);
        cycle(0, 0, 1, 0);
        check("t1_valid_drop", usb.data_in_valid, 0);
        check("t1_count_zero", count, 0);

        // Fill output stage plus storage, then overflow, then flush.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 8'(8'h10 + i), 0, 0);
        check("fill_count", count, DEPTH + 1);
        check("fill_full", full, 1);
        check("fill_no_ovf", overflow, 0);
        cycle(1, 8'hAA, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, DEPTH + 1);
        cycle(1, 8'hBB, 1, 0);
        check("ovf_strobe_drop_count", count, DEPTH);
        cycle(1, 8'hCC, 1, 1);
        check("flush_count", count, 0);
        check("flush_ovf", overflow, 0);
        check("flush_valid", usb.data_in_valid, 0);

        // Five queued bytes drained by a strobe held for five cycles.
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
        check("burst_count", count, 0);
        check("burst_valid", usb.data_in_valid, 0);

        // Strobes with nothing loaded are ignored.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        check("idle_strobe_count", count, 0);
        check("idle_strobe_full", full, 0);

`ifndef USB_TX_FEEDER_PATTERN_EN
        // Without the generator, a pattern request does nothing.
        pattern_start = 8'hFE;
        pattern_en    = 1'b1;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("nopat_busy", pattern_busy, 0);
        check("nopat_valid", usb.data_in_valid, 0);
        pattern_en = 1'b0;
`endif

        // Random traffic: a filling phase then a draining phase, rare flushes.
        for (int i = 0; i < 600; i++) begin
            int s_pct;
            s_pct = (i < 300) ? 25 : 75;
`ifndef USB_TX_FEEDER_PATTERN_EN
            pattern_en = $urandom_range(0, 1);
`endif
            cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < s_pct,
                  $urandom_range(0, 99) == 0);
        end
        cycle(0, 0, 0, 1);
        pattern_en = 1'b0;
        cycle(0, 0, 0, 0);

`ifdef USB_TX_FEEDER_PATTERN_EN
        // Pattern run FE, FF, 00 with 0x55 written mid-run.
        begin
            bit fell_checked;
            fell_checked  = 1'b0;
            model_on      = 1'b0;
            seen_q.delete();
            pattern_start = 8'hFE;
            pattern_en    = 1'b1;
            cycle(0, 0, 0, 0);
            check("pat_busy_rise", pattern_busy, 1);
            pattern_en = 1'b0;
            for (int k = 0; k < 30 && seen_q.size() < PATTERN_LEN + 1; k++) begin
                cycle(k == 1, 8'h55, usb.data_in_valid, 0);
                if (seen_q.size() < PATTERN_LEN) begin
                    check("pat_busy_hold", pattern_busy, 1);
                end else if (seen_q.size() == PATTERN_LEN && !fell_checked) begin
                    check("pat_busy_fall", pattern_busy, 0);
                    fell_checked = 1'b1;
                end
            end
            cycle(0, 0, 0, 0);
            check("pat_seen_len", seen_q.size(), PATTERN_LEN + 1);
            for (int i = 0; i < seen_q.size() && i < PATTERN_LEN + 1; i++) begin
                logic [DATA_W-1:0] exp_b;
                exp_b = (i < PATTERN_LEN) ? 8'(8'hFE + i) : 8'h55;
                check("pat_byte", seen_q[i], exp_b);
            end
            check("pat_end_valid", usb.data_in_valid, 0);
            check("pat_end_busy", pattern_busy, 0);
            model_on = 1'b1;
        end
`endif

        // Asynchronous reset while a byte is loaded.
        cycle(1, 8'h77, 0, 0);
        check("pre_rst_valid", usb.data_in_valid, 1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", usb.data_in_valid, 0);
        check("async_rst_count", count, 0);
        @(posedge clk_48);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        check("post_rst_empty", usb.data_in_valid, 0);
        cycle(1, 8'h42, 0, 0);
        check("post_rst_write_valid", usb.data_in_valid, 1);
        check("post_rst_write_data", usb.data_in, 8'h42);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
